decode_group_splitter: RTL
==========================

// Module: decode_group_splitter
//
// PURPOSE
// Sits between the decode pipeline register and the rename stage.
// Guarantees the rename stage's serialization rule: a serialized op (CSR, fence, env) always reaches rename alone, in lane 0.
// Holds one decoded group and emits it over one or more cycles.
// Each cycle it emits either a run of non-serialized ops, or a single serialized op.
// Back-pressures decode until the held group is fully drained.
//
// PARAMETERS
// WIDTH      2   lanes per group; equals RENAME_WIDTH (and DECODE_WIDTH)
// PAYLOAD_W  64  opaque per-lane payload width (opInfo, pc, bPred, opId packed by the wrapper)
//
// PORTS
// clk          in   1                  clock
// rst          in   1                  reset; synchronous, active-high
// flush        in   1                  pipeline clear for rename; drops the held group
// in_valid     in   WIDTH              per-lane valid of the decoded group
// in_ser       in   WIDTH              per-lane serialized flag (opInfo.serialized)
// in_payload   in   WIDTH*PAYLOAD_W    per-lane payload
// in_ready     out  1                  group is accepted at this clock edge; decode advances
// out_stall    in   1                  rename stage stall (ctrl.rnStage.stall)
// out_valid    out  WIDTH              per-lane valid presented to rename
// out_payload  out  WIDTH*PAYLOAD_W    per-lane payload presented to rename
// out_last     out  1                  current emission drains the held group
//
// BEHAVIOUR
// State:
// - grp_valid[WIDTH] marks lanes not yet emitted.
// - grp_ser[WIDTH] and grp_payload hold the group.
// - The block is "empty" when grp_valid == 0.
//
// Scan (combinational over the registers):
// - start = lowest i with grp_valid[i].
// - If grp_ser[start]: end = start+1.
// - Otherwise: end = lowest j > start with grp_valid[j] && grp_ser[j]; if there is no such j, end = WIDTH.
// - start and end are $clog2(WIDTH)+1 bits wide, so WIDTH itself is representable.
//
// Output lanes (compacted to lane 0):
// - out_payload[k] = grp_payload[start+k].
// - out_valid[k] = grp_valid[start+k] && (start+k < end) && !flush.
// - Invalid lanes inside the run stay invalid holes.
// - Lanes beyond WIDTH-1-start are invalid.
// - A serialized op is therefore always alone, in lane 0.
//
// Emission and acceptance:
// - emit = !empty && !out_stall && !flush.
// - On emit, grp_valid[start..end-1] is cleared.
// - out_last = !empty && no grp_valid bit at index >= end.
// - in_ready = !flush && (empty || (emit && out_last)).
// - On in_ready: grp_* <= in_*. An all-invalid input makes the block empty.
// - Latency: an op presented with in_ready high appears on out_valid the next cycle.
// - Throughput: 1 group/cycle if no lane is serialized.
// - A group with S serialized lanes needs up to 2S+1 emit cycles.
//
// Stall:
// - While out_stall is high, registers hold and out_* is stable.
// - If the block is empty, in_ready is still 1, so a group may load during the stall.
//
// Flush and reset:
// - flush: grp_valid <= 0 at the edge; out_valid = 0 and in_ready = 0 in that same cycle; the input in that cycle is discarded.
// - flush has priority over out_stall.
// - rst, including mid-drain: grp_valid <= 0.
// - Reset outputs: out_valid = 0, out_last = 0, in_ready = 1 (after reset deasserts).
// - grp_payload and grp_ser are not reset.
//
// Assertions:
// - out_valid[k>0] is never set together with a serialized lane-0 op.
// - in_ready && flush is never true.
//
// STRUCTURE
// - PipelineTypes gains: typedef logic [PAYLOAD_W-1:0] SplitPayload; constant SPLIT_IDX_W = $clog2(RENAME_WIDTH)+1.
// - One sub-module, decode_group_splitter_scan: pure combinational start/end/last finder over grp_valid and grp_ser.
// - The top level holds the registers, shift mux, and handshake.
//
// TESTING
// Run at WIDTH=4 unless noted.
// 1. No serialized lanes, valid=1111, out_stall=0, back-to-back groups:
//    -> one group per cycle, out_last=1 every cycle, in_ready stays 1.
// 2. valid=1111, ser=0100 (lane 2 serialized):
//    -> cycle 1 lanes 0-1 valid, out_last=0;
//    -> cycle 2 lane 0 = old lane 2 only;
//    -> cycle 3 lane 0 = old lane 3, out_last=1, in_ready=1.
// 3. valid=1011 (lane 2 is a hole), ser=0001 (lane 0 serialized):
//    -> cycle 1 lane 0 only;
//    -> cycle 2 out_valid=0101 (old lanes 1 and 3, hole preserved), out_last=1.
// 4. out_stall=1 for 3 cycles in the middle of case 2:
//    -> out_payload/out_valid stable, in_ready=0;
//    -> drain resumes unchanged after stall drops.
// 5. flush in cycle 2 of case 2:
//    -> out_valid=0, in_ready=0 that cycle;
//    -> next cycle empty, in_ready=1; the remaining ops are never emitted.
// 6. rst asserted mid-drain, then a new group:
//    -> after reset out_valid=0, in_ready=1;
//    -> the new group emits one cycle after loading. Repeat case 2 at WIDTH=2.

Source files
------------

// File: rtl/decode_group_splitter_pkg.sv
// Shared types and constants for the decode-to-rename group splitter.
// Index width is sized so that a lane count equal to the group width is representable.
// The payload is opaque here; the wrapper packs opInfo, pc, bPred and opId into it.
package decode_group_splitter_pkg;

  localparam int RENAME_WIDTH    = 2;
  localparam int SPLIT_PAYLOAD_W = 64;

  // Width of a lane index that can also hold the value WIDTH itself.
  function automatic int split_idx_w(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int SPLIT_IDX_W = split_idx_w(RENAME_WIDTH);

  typedef logic [SPLIT_PAYLOAD_W-1:0] SplitPayload;

endpackage

// File: rtl/decode_group_splitter_scan.sv
// Finds the next emission run in the held group: start lane, end lane and drain flag.
// Latency: purely combinational.
// Backpressure: none; it only observes the group registers.
module decode_group_splitter_scan
  import decode_group_splitter_pkg::*;
#(
  parameter int WIDTH = RENAME_WIDTH,
  parameter int IDX_W = split_idx_w(RENAME_WIDTH)
) (
  input  logic [WIDTH-1:0] grp_valid,
  input  logic [WIDTH-1:0] grp_ser,
  output logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] run_end,
  output logic             start_ser,
  output logic             empty,
  output logic             last
);

  // Locate the first pending lane, the end of its run, and whether the run drains the group.
  always_comb begin
    start     = IDX_W'(WIDTH);
    start_ser = 1'b0;
    empty     = 1'b1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (grp_valid[i]) begin
        start     = IDX_W'(i);
        start_ser = grp_ser[i];
        empty     = 1'b0;
      end
    end

    // A serialized op is a run of one; otherwise the run stops before the next serialized op.
    run_end = IDX_W'(WIDTH);
    if (!empty && start_ser) begin
      run_end = start + IDX_W'(1);
    end else begin
      for (int j = WIDTH - 1; j >= 0; j--) begin
        if ((IDX_W'(j) > start) && grp_valid[j] && grp_ser[j]) begin
          run_end = IDX_W'(j);
        end
      end
    end

    last = !empty;
    for (int j = 0; j < WIDTH; j++) begin
      if ((IDX_W'(j) >= run_end) && grp_valid[j]) begin
        last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/decode_group_splitter.sv
// Holds one decoded group and emits it to rename as non-serialized runs or lone serialized ops.
// Latency: one cycle from acceptance (in_ready high) to out_valid.
// Backpressure: in_ready is low until the held group drains; out_stall freezes the block.
module decode_group_splitter
  import decode_group_splitter_pkg::*;
#(
  parameter int WIDTH     = RENAME_WIDTH,
  parameter int PAYLOAD_W = SPLIT_PAYLOAD_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           in_valid,
  input  logic [WIDTH-1:0]           in_ser,
  input  logic [WIDTH*PAYLOAD_W-1:0] in_payload,
  output logic                       in_ready,
  input  logic                       out_stall,
  output logic [WIDTH-1:0]           out_valid,
  output logic [WIDTH*PAYLOAD_W-1:0] out_payload,
  output logic                       out_last
);

  localparam int IDX_W = split_idx_w(WIDTH);

  logic [WIDTH-1:0]     grp_valid;
  logic [WIDTH-1:0]     grp_ser;
  logic [PAYLOAD_W-1:0] grp_payload [WIDTH];

  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] run_end;
  logic             start_ser;
  logic             empty;
  logic             last;
  logic             emit;
  logic [WIDTH-1:0] run_mask;

  decode_group_splitter_scan #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_scan (
    .grp_valid (grp_valid),
    .grp_ser   (grp_ser),
    .start     (start),
    .run_end   (run_end),
    .start_ser (start_ser),
    .empty     (empty),
    .last      (last)
  );

  // Handshake: emit when rename can take the run; accept a new group only once the old one drains.
  always_comb begin
    emit     = !empty && !out_stall && !flush;
    out_last = last;
    in_ready = !flush && (empty || (emit && last));
  end

  // Shift the run down to lane 0; lanes past the run end or past the group are invalid.
  always_comb begin
    out_valid   = '0;
    out_payload = '0;
    for (int k = 0; k < WIDTH; k++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (IDX_W'(j) == start + IDX_W'(k)) begin
          out_payload[k*PAYLOAD_W +: PAYLOAD_W] = grp_payload[j];
          out_valid[k] = grp_valid[j] && (IDX_W'(j) < run_end) && !flush;
        end
      end
    end
  end

  // Lanes covered by the current run, retired when it is emitted.
  always_comb begin
    run_mask = '0;
    for (int j = 0; j < WIDTH; j++) begin
      run_mask[j] = (IDX_W'(j) >= start) && (IDX_W'(j) < run_end);
    end
  end

  // Pending-lane mask: cleared by reset/flush, loaded on accept, retired on emit.
  always_ff @(posedge clk) begin
    if (rst) begin
      grp_valid <= '0;
    end else if (flush) begin
      grp_valid <= '0;
    end else if (in_ready) begin
      grp_valid <= in_valid;
    end else if (emit) begin
      grp_valid <= grp_valid & ~run_mask;
    end
  end

  // Group contents; not reset because they are only observed through grp_valid.
  always_ff @(posedge clk) begin
    if (in_ready) begin
      grp_ser <= in_ser;
      for (int i = 0; i < WIDTH; i++) begin
        grp_payload[i] <= in_payload[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  // A new group is never accepted in a flush cycle.
  a_no_ready_on_flush : assert property (@(posedge clk) disable iff (rst) !(in_ready && flush));

  generate
    if (WIDTH > 1) begin : g_ser_alone
      // A serialized op reaches rename alone in lane 0.
      a_ser_alone : assert property (@(posedge clk) disable iff (rst)
        (out_valid[0] && start_ser) |-> (out_valid[WIDTH-1:1] == '0));
    end
  endgenerate

endmodule
